// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter and the bus FSM that reuses
// the default address/data widths.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int SRAM_ADDR_W = 21;
  localparam int SRAM_DATA_W = 8;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin picker: on contention the port not granted last wins.
module sram_rr_pick
  import sram_pkg::*;
(
  input  logic [1:0] reqs_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  // Grant selection from the live request pair
  always_comb begin
    grant_valid_o = |reqs_i;
    case (reqs_i)
      2'b01:   grant_id_o = PORT_A;
      2'b10:   grant_id_o = PORT_B;
      2'b11:   grant_id_o = (last_grant_i == PORT_A) ? PORT_B : PORT_A;
      default: grant_id_o = PORT_A;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between port A (host) and port B (cartridge),
// producing registered CE/OE/WE sequences with a WAIT_CYCLES-wide strobe.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              dout_en_q, dout_en_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              grant_valid_s, grant_id_s, capture_s;

  sram_rr_pick u_pick (
    .reqs_i        ({b_req, a_req}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid_s),
    .grant_id_o    (grant_id_s)
  );

  // State and latched-access registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      last_grant_q <= PORT_B;
      owner_q      <= PORT_A;
      wr_q         <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      dout_q       <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      dout_q       <= dout_d;
    end
  end

  // Next state; the winner's request is copied only at the IDLE->SETUP edge
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    dout_d       = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_d      = ST_SETUP;
          owner_d      = grant_id_s;
          last_grant_d = grant_id_s;
          if (grant_id_s == PORT_A) begin
            wr_d   = a_we;
            addr_d = a_addr;
            dout_d = a_wdata;
          end else begin
            wr_d   = b_we;
            addr_d = b_addr;
            dout_d = b_wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = CNT_LOAD;
      end
      ST_STROBE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_STROBE;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pin and ack values are decoded from the upcoming state so they register cleanly
  always_comb begin
    capture_s = (state_q == ST_STROBE) && (cnt_q == CNT_ZERO) && !wr_q;
    ce_n_d    = (state_d == ST_IDLE);
    oe_n_d    = !((state_d == ST_STROBE) && !wr_d);
    we_n_d    = !((state_d == ST_STROBE) && wr_d);
    dout_en_d = (state_d != ST_IDLE) && wr_d;
    a_ack_d   = (state_d == ST_FINISH) && (owner_d == PORT_A);
    b_ack_d   = (state_d == ST_FINISH) && (owner_d == PORT_B);
    if (capture_s && (owner_q == PORT_A)) begin
      a_rdata_d = sram_din;
    end else begin
      a_rdata_d = a_rdata_q;
    end
    if (capture_s && (owner_q == PORT_B)) begin
      b_rdata_d = sram_din;
    end else begin
      b_rdata_d = b_rdata_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      dout_en_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= {DATA_W{1'b0}};
      b_rdata_q <= {DATA_W{1'b0}};
    end else begin
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      dout_en_q <= dout_en_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign sram_addr    = addr_q;
  assign sram_dout    = dout_q;
  assign sram_dout_en = dout_en_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign a_ack        = a_ack_q;
  assign b_ack        = b_ack_q;
  assign a_rdata      = a_rdata_q;
  assign b_rdata      = b_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed + randomized bench for sram_arbiter with an emulated SRAM device and
// a transaction-level memory/arbitration model.
module tb_sram_arbiter;

  localparam int W = 2;

  logic        clk, reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [20:0] a_addr, b_addr, sram_addr;
  logic [7:0]  a_wdata, a_rdata, b_wdata, b_rdata, sram_dout, sram_din;
  logic        a_ack, b_ack, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;

  logic        a1_req, a1_we, b1_req, b1_we;
  logic [20:0] a1_addr, b1_addr, sram1_addr;
  logic [7:0]  a1_wdata, a1_rdata, b1_wdata, b1_rdata, sram1_dout, sram1_din;
  logic        a1_ack, b1_ack, sram1_dout_en, sram1_ce_n, sram1_oe_n, sram1_we_n;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // emulated SRAM device (pins) and transaction-level expectation
  logic [7:0] mem [256];
  bit         mvalid [256];
  logic [7:0] exp_mem [256];
  bit         exp_valid [256];
  bit         pend;
  logic [7:0] paddr, pdata;
  logic       din_ovr_en;
  logic [7:0] din_ovr;
  logic       exp_last;

  int          ce_run, oe_run, we_run, en_run;
  logic [20:0] hold_addr;
  logic [7:0]  hold_dout;

  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .a_req(a1_req), .a_we(a1_we), .a_addr(a1_addr), .a_wdata(a1_wdata), .a_rdata(a1_rdata), .a_ack(a1_ack),
    .b_req(b1_req), .b_we(b1_we), .b_addr(b1_addr), .b_wdata(b1_wdata), .b_rdata(b1_rdata), .b_ack(b1_ack),
    .sram_addr(sram1_addr), .sram_dout(sram1_dout), .sram_dout_en(sram1_dout_en), .sram_din(sram1_din),
    .sram_ce_n(sram1_ce_n), .sram_oe_n(sram1_oe_n), .sram_we_n(sram1_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction

  always_comb begin
    if (din_ovr_en)                  sram_din = din_ovr;
    else if (mvalid[sram_addr[7:0]]) sram_din = mem[sram_addr[7:0]];
    else                             sram_din = dflt(sram_addr[7:0]);
  end

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    return exp_valid[a] ? exp_mem[a] : dflt(a);
  endfunction

  function automatic logic [20:0] rnd_addr();
    logic [31:0] r;
    r = $urandom;
    return {r[20:8], 5'd0, r[2:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // one clock: sample at negedge, emulate SRAM writes, check pin protocol
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!reset_n) begin
      pend = 1'b0; ce_run = 0; oe_run = 0; we_run = 0; en_run = 0;
    end else begin
      if (!sram_ce_n && !sram_we_n) begin
        pend = 1'b1; paddr = sram_addr[7:0]; pdata = sram_dout;
      end else if (pend) begin
        mem[paddr] = pdata; mvalid[paddr] = 1'b1; pend = 1'b0;
      end
      chk("oe_we_excl", 32'(sram_oe_n | sram_we_n), 32'd1);
      if (!sram_ce_n) begin
        if (ce_run > 0) begin
          chk("addr_stable", 32'(sram_addr), 32'(hold_addr));
          chk("dout_stable", 32'(sram_dout), 32'(hold_dout));
        end
        if (!sram_oe_n) chk("rd_dout_en", 32'(sram_dout_en), 32'd0);
        ce_run++;
        oe_run += int'(!sram_oe_n);
        we_run += int'(!sram_we_n);
        en_run += int'(sram_dout_en);
        hold_addr = sram_addr;
        hold_dout = sram_dout;
      end else if (ce_run > 0) begin
        chk("ce_len", 32'(ce_run), 32'(W + 2));
        chk("strobe_len", 32'(oe_run + we_run), 32'(W));
        chk("strobe_kind", 32'((oe_run == 0) || (we_run == 0)), 32'd1);
        chk("dout_en_len", 32'(en_run), 32'((we_run > 0) ? W + 2 : 0));
        ce_run = 0; oe_run = 0; we_run = 0; en_run = 0;
      end
    end
  endtask

  task automatic single_access(input bit pb, input bit we, input logic [20:0] addr,
                               input logic [7:0] wd, input string tag);
    logic [7:0] other_before, want, got;
    int c0;
    bit done, other_seen;
    other_before = pb ? a_rdata : b_rdata;
    want = din_ovr_en ? din_ovr : model_rd(addr[7:0]);
    if (pb) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1; end
    else    begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1; end
    c0 = cyc; done = 1'b0; other_seen = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if ((pb ? a_ack : b_ack) === 1'b1) other_seen = 1'b1;
      if ((pb ? b_ack : a_ack) === 1'b1) begin
        done = 1'b1;
        chk({tag, "_lat"}, 32'(cyc - c0), 32'(W + 2));
        chk({tag, "_addr"}, 32'(sram_addr), 32'(addr));
        if (we) begin
          chk({tag, "_dout"}, 32'(sram_dout), 32'(wd));
          exp_mem[addr[7:0]] = wd; exp_valid[addr[7:0]] = 1'b1;
        end else begin
          got = pb ? b_rdata : a_rdata;
          chk({tag, "_rdata"}, 32'(got), 32'(want));
        end
        exp_last = pb;
        if (pb) b_req = 1'b0; else a_req = 1'b0;
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    if (pb) b_req = 1'b0; else a_req = 1'b0;
    tick();
    chk({tag, "_ack_pulse"}, 32'(pb ? b_ack : a_ack), 32'd0);
    chk({tag, "_other_ack"}, 32'(other_seen), 32'd0);
    chk({tag, "_other_rdata"}, 32'(pb ? a_rdata : b_rdata), 32'(other_before));
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  a_before, want_b;
    int c0, n, prev, oe1;
    bit done, a_seen, ce_idle, pb;

    reset_n = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 21'd0; a_wdata = 8'd0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 21'd0; b_wdata = 8'd0;
    a1_req = 1'b0; a1_we = 1'b0; a1_addr = 21'd0; a1_wdata = 8'd0;
    b1_req = 1'b0; b1_we = 1'b0; b1_addr = 21'd0; b1_wdata = 8'd0;
    sram1_din = 8'h96;
    din_ovr_en = 1'b0; din_ovr = 8'd0;
    pend = 1'b0; paddr = 8'd0; pdata = 8'd0;
    ce_run = 0; oe_run = 0; we_run = 0; en_run = 0;
    hold_addr = 21'd0; hold_dout = 8'd0;
    exp_last = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_dout_en", 32'(sram_dout_en), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dout", 32'(sram_dout), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    chk("rst_ack", 32'({a_ack, b_ack}), 32'd0);
    reset_n = 1'b1;
    tick();

    // single A read with a forced pin value
    din_ovr_en = 1'b1; din_ovr = 8'h5A;
    single_access(1'b0, 1'b0, 21'h1ABCD, 8'h00, "a_read");
    din_ovr_en = 1'b0;
    // single B write, then read it back through A
    single_access(1'b1, 1'b1, 21'h00010, 8'hC3, "b_write");
    single_access(1'b0, 1'b0, 21'h00010, 8'h00, "a_readback");

    // randomized single-port accesses against the memory model
    for (int k = 0; k < 16; k++) begin
      r = $urandom;
      single_access(r[0], r[1], rnd_addr(), r[15:8], "rnd");
    end

    // A requests while B is busy and withdraws before B finishes
    a_before = a_rdata;
    b_we = 1'b0; b_addr = rnd_addr(); b_req = 1'b1;
    want_b = model_rd(b_addr[7:0]);
    done = 1'b0; a_seen = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (i == 1) begin a_we = 1'b0; a_addr = rnd_addr(); a_req = 1'b1; end
      if (i == 2) a_req = 1'b0;
      if (a_ack === 1'b1) a_seen = 1'b1;
      if (b_ack === 1'b1) begin
        done = 1'b1;
        chk("wd_b_rdata", 32'(b_rdata), 32'(want_b));
        b_req = 1'b0;
      end
    end
    chk("wd_b_done", 32'(done), 32'd1);
    ce_idle = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_ack === 1'b1) a_seen = 1'b1;
      if (sram_ce_n !== 1'b1) ce_idle = 1'b0;
    end
    chk("wd_no_a_ack", 32'(a_seen), 32'd0);
    chk("wd_idle", 32'(ce_idle), 32'd1);
    chk("wd_a_rdata", 32'(a_rdata), 32'(a_before));

    // asynchronous reset in the middle of an A write strobe
    a_we = 1'b1; a_addr = 21'h00055; a_wdata = 8'hE7; a_req = 1'b1;
    tick(); tick();
    chk("mid_we_low", 32'(sram_we_n), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'd7);
    chk("mid_rst_dout_en", 32'(sram_dout_en), 32'd0);
    a_req = 1'b0;
    tick(); tick();
    chk("mid_rst_ack", 32'({a_ack, b_ack}), 32'd0);
    chk("mid_rst_rdata", 32'(a_rdata), 32'd0);
    reset_n = 1'b1;
    exp_last = 1'b1;
    tick();
    din_ovr_en = 1'b1; din_ovr = 8'h77;
    single_access(1'b0, 1'b0, 21'h00123, 8'h00, "post_rst_read");
    din_ovr_en = 1'b0;

    // contention from reset: both ports continuously requesting
    reset_n = 1'b0;
    r = $urandom; a_we = r[0]; a_addr = rnd_addr(); a_wdata = r[15:8]; a_req = 1'b1;
    r = $urandom; b_we = r[0]; b_addr = rnd_addr(); b_wdata = r[15:8]; b_req = 1'b1;
    tick();
    reset_n = 1'b1;
    exp_last = 1'b1;
    n = 0; prev = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      tick();
      if (a_ack === 1'b1 || b_ack === 1'b1) begin
        pb = (b_ack === 1'b1);
        chk("ct_single_ack", 32'(a_ack & b_ack), 32'd0);
        chk("ct_order", 32'(pb), 32'(!exp_last));
        if (n > 0) chk("ct_gap", 32'(cyc - prev), 32'(W + 3));
        prev = cyc;
        if (pb ? b_we : a_we) begin
          chk("ct_dout", 32'(sram_dout), 32'(pb ? b_wdata : a_wdata));
          if (pb) begin exp_mem[b_addr[7:0]] = b_wdata; exp_valid[b_addr[7:0]] = 1'b1; end
          else    begin exp_mem[a_addr[7:0]] = a_wdata; exp_valid[a_addr[7:0]] = 1'b1; end
        end else begin
          chk("ct_rdata", 32'(pb ? b_rdata : a_rdata),
              32'(model_rd(pb ? b_addr[7:0] : a_addr[7:0])));
        end
        exp_last = pb;
        r = $urandom;
        if (pb) begin b_we = r[0]; b_addr = rnd_addr(); b_wdata = r[15:8]; end
        else    begin a_we = r[0]; a_addr = rnd_addr(); a_wdata = r[15:8]; end
        n++;
      end
    end
    chk("ct_count", 32'(n), 32'd6);
    a_req = 1'b0; b_req = 1'b0;
    repeat (2) tick();

    // single-cycle strobe build
    a1_we = 1'b0; a1_addr = rnd_addr(); a1_req = 1'b1;
    c0 = cyc; oe1 = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      if (sram1_oe_n === 1'b0) oe1++;
      if (a1_ack === 1'b1) begin
        done = 1'b1;
        chk("w1_lat", 32'(cyc - c0), 32'd3);
        chk("w1_rdata", 32'(a1_rdata), 32'h96);
        a1_req = 1'b0;
      end
    end
    chk("w1_done", 32'(done), 32'd1);
    chk("w1_oe_len", 32'(oe1), 32'd1);
    a1_req = 1'b0;
    tick();
    chk("w1_ack_pulse", 32'(a1_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
